// File: rtl/bc_collect_buffer_pkg.sv
// Shared types for the broadcast collect path: element width and the default
// depth of the wide-beat output queue.
package bc_collect_buffer_pkg;
  localparam int unsigned ELEN = 64;
  typedef logic [ELEN-1:0] elen_t;
  localparam int unsigned BC_COLLECT_DEPTH = 4;
endpackage

// File: rtl/bc_collect_buffer_fifo.sv
// Registered-output FIFO holding committed wide beats.
// Flush wins over push/pop, and both flush and reset zero the storage.
module bc_collect_buffer_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4,
  localparam int unsigned UsageWidth = $clog2(Depth+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic                  pop_i,
  output logic [DataWidth-1:0]  data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o
);
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0][DataWidth-1:0] mem_q;
  logic [AddrW-1:0]      rd_q, wr_q;
  logic [UsageWidth-1:0] cnt_q;
  logic                  do_push, do_pop;

  // Pointers wrap explicitly so a non-power-of-two depth also works.
  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(Depth-1)) ? '0 : p + AddrW'(1);
  endfunction

  assign full_o  = (cnt_q == UsageWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign usage_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + UsageWidth'(do_push) - UsageWidth'(do_pop);
    end
  end
endmodule

// File: rtl/bc_collect_buffer.sv
// Packs the serial lane0 element stream into NrLanes-wide beats and queues them
// for the store unit with a per-lane enable mask.
module bc_collect_buffer import bc_collect_buffer_pkg::*; #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned Depth   = BC_COLLECT_DEPTH,
  localparam int unsigned IdxWidth   = $clog2(NrLanes),
  localparam int unsigned UsageWidth = $clog2(Depth+1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  elen_t                   elem_i,
  input  logic                    elem_valid_i,
  input  logic                    elem_last_i,
  output logic                    elem_ready_o,
  output logic [NrLanes*ELEN-1:0] stu_data_o,
  output logic [NrLanes-1:0]      stu_lane_en_o,
  output logic                    stu_last_o,
  output logic                    stu_valid_o,
  input  logic                    stu_ready_i,
  output logic [UsageWidth-1:0]   usage_o
);
  typedef struct packed {
    elen_t [NrLanes-1:0] data;
    logic  [NrLanes-1:0] lane_en;
    logic                last;
  } bc_beat_t;

  logic [IdxWidth-1:0] idx_q;
  elen_t [NrLanes-1:0] pack_data_q, pack_data_d;
  logic  [NrLanes-1:0] pack_en_q, pack_en_d;
  logic                acc, commit, full, empty;
  bc_beat_t            beat_in, beat_head;

  // Ready depends only on queue occupancy, never on stu_ready_i.
  assign elem_ready_o = !full;
  assign acc          = elem_valid_i && elem_ready_o;
  assign commit       = acc && ((idx_q == IdxWidth'(NrLanes-1)) || elem_last_i);

  for (genvar l = 0; l < NrLanes; l++) begin : g_lane
    logic hit;
    assign hit            = acc && (idx_q == IdxWidth'(l));
    assign pack_data_d[l] = hit ? elem_i : pack_data_q[l];
    assign pack_en_d[l]   = hit | pack_en_q[l];
  end

  assign beat_in.data    = pack_data_d;
  assign beat_in.lane_en = pack_en_d;
  assign beat_in.last    = elem_last_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      pack_data_q <= '0;
      pack_en_q   <= '0;
    end else if (flush_i || commit) begin
      idx_q       <= '0;
      pack_data_q <= '0;
      pack_en_q   <= '0;
    end else if (acc) begin
      idx_q       <= idx_q + IdxWidth'(1);
      pack_data_q <= pack_data_d;
      pack_en_q   <= pack_en_d;
    end
  end

  bc_collect_buffer_fifo #(
    .DataWidth ($bits(bc_beat_t)),
    .Depth     (Depth)
  ) i_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (commit),
    .data_i  (beat_in),
    .pop_i   (stu_valid_o && stu_ready_i),
    .data_o  (beat_head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage_o)
  );

  // Stale slots behind the read pointer are never exposed once the queue drains.
  assign stu_valid_o   = !empty;
  assign stu_data_o    = empty ? '0 : beat_head.data;
  assign stu_lane_en_o = empty ? '0 : beat_head.lane_en;
  assign stu_last_o    = empty ? 1'b0 : beat_head.last;
endmodule

// File: tb/tb_bc_collect_buffer.sv
// Bench for bc_collect_buffer (NrLanes=4, Depth=2): table-driven vectors plus a
// beat scoreboard, with hand sequences for backpressure, flush and reset.
module tb_bc_collect_buffer;
  import bc_collect_buffer_pkg::*;
  localparam int LANES = 4;
  localparam int DEPTH = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          flush = 0;
  elen_t         elem = '0;
  logic          elem_valid = 0, elem_last = 0, stu_ready = 0;
  logic          elem_ready, stu_last, stu_valid;
  logic [255:0]  stu_data;
  logic [3:0]    stu_en;
  logic [1:0]    usage;

  bc_collect_buffer #(.NrLanes(LANES), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .elem_i(elem), .elem_valid_i(elem_valid), .elem_last_i(elem_last),
    .elem_ready_o(elem_ready), .stu_data_o(stu_data), .stu_lane_en_o(stu_en),
    .stu_last_o(stu_last), .stu_valid_o(stu_valid), .stu_ready_i(stu_ready),
    .usage_o(usage)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][63:0] data;
    logic [3:0]       en;
    logic             last;
  } tb_beat_t;

  typedef struct {
    logic v; elen_t e; logic l; logic r;
    logic exp_valid; logic [3:0] exp_en; logic exp_last; int exp_usage;
  } vec_t;

  tb_beat_t         exp_q[$];
  vec_t             tbl[$];
  logic [3:0][63:0] m_data = '0;
  logic [3:0]       m_en = '0;
  int               m_idx = 0;
  int               n_pass = 0, n_total = 0;
  logic             last_acc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_idx = 0; m_data = '0; m_en = '0;
  endtask

  task automatic check_outputs();
    chk("elem_ready", elem_ready, exp_q.size() < DEPTH);
    chk("stu_valid", stu_valid, exp_q.size() != 0);
    chk("usage", usage, exp_q.size());
    if (exp_q.size() != 0) begin
      chk("stu_data", stu_data, exp_q[0].data);
      chk("stu_lane_en", stu_en, exp_q[0].en);
      chk("stu_last", stu_last, exp_q[0].last);
    end
  endtask

  // Drive one cycle: check current outputs, step the clock, update the model.
  task automatic cycle(input logic v, input elen_t e, input logic l, input logic r, input logic f);
    logic acc, pop;
    tb_beat_t b;
    elem_valid = v; elem = e; elem_last = l; stu_ready = r; flush = f;
    check_outputs();
    acc = v && (exp_q.size() < DEPTH);
    pop = (exp_q.size() != 0) && r;
    @(posedge clk); #1;
    if (f) model_clear();
    else begin
      if (pop) b = exp_q.pop_front();
      if (acc) begin
        m_data[m_idx] = e;
        m_en[m_idx]   = 1'b1;
        if (m_idx == LANES-1 || l) begin
          b.data = m_data; b.en = m_en; b.last = l;
          exp_q.push_back(b);
          m_idx = 0; m_data = '0; m_en = '0;
        end else m_idx++;
      end
    end
    last_acc = acc && !f;
    elem_valid = 0; flush = 0;
  endtask

  task automatic feed(input elen_t e, input logic l, input logic r);
    int tries = 0;
    do begin
      cycle(1'b1, e, l, r, 1'b0);
      tries++;
    end while (!last_acc && tries < 20);
    if (!last_acc) chk("feed_timeout", 0, 1);
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic add_vec(input logic v, input elen_t e, input logic l, input logic r,
                         input logic ev, input logic [3:0] een, input logic el, input int eu);
    vec_t t;
    t.v = v; t.e = e; t.l = l; t.r = r;
    t.exp_valid = ev; t.exp_en = een; t.exp_last = el; t.exp_usage = eu;
    tbl.push_back(t);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, stu_valid, 0);
    chk({tag, "_usage"}, usage, 0);
    chk({tag, "_data"}, stu_data, 0);
    chk({tag, "_lane_en"}, stu_en, 0);
    chk({tag, "_last"}, stu_last, 0);
    chk({tag, "_ready"}, elem_ready, 1);
  endtask

  initial begin
    #3;
    check_reset_vals("reset");
    #9 rst_n = 1;
    @(posedge clk); #1;

    // Full beats, partial tail, single-element vector; expectations after each edge.
    for (int i = 0; i < 8; i++)
      add_vec(1, elen_t'(64'h10 + i), i == 7, 1,
              i == 3 || i == 7, (i == 3 || i == 7) ? 4'b1111 : 4'b0000, i == 7,
              (i == 3 || i == 7) ? 1 : 0);
    add_vec(0, '0, 0, 1, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 6; i++)
      add_vec(1, elen_t'(64'hA0 + i), i == 5, 1,
              i == 3 || i == 5, (i == 3) ? 4'b1111 : (i == 5) ? 4'b0011 : 4'b0000, i == 5,
              (i == 3 || i == 5) ? 1 : 0);
    add_vec(0, '0, 0, 1, 0, 4'b0000, 0, 0);
    add_vec(1, 64'hB0, 1, 1, 1, 4'b0001, 1, 1);
    add_vec(0, '0, 0, 1, 0, 4'b0000, 0, 0);
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].e, tbl[i].l, tbl[i].r, 1'b0);
      chk($sformatf("vec%0d_valid", i), stu_valid, tbl[i].exp_valid);
      chk($sformatf("vec%0d_usage", i), usage, tbl[i].exp_usage);
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_lane_en", i), stu_en, tbl[i].exp_en);
        chk($sformatf("vec%0d_last", i), stu_last, tbl[i].exp_last);
      end
    end
    chk("tail_lane2_zero", stu_data[128 +: 64], 0);

    // Backpressure: queue fills, element 9 is held, one pop frees a slot.
    for (int i = 0; i < 8; i++) feed(elen_t'(64'h20 + i), 1'b0, 1'b0);
    chk("bp_usage_full", usage, 2);
    chk("bp_ready_low", elem_ready, 0);
    repeat (3) cycle(1'b1, 64'h28, 1'b0, 1'b0, 1'b0);
    chk("bp_held_usage", usage, 2);
    cycle(1'b1, 64'h28, 1'b0, 1'b1, 1'b0);
    chk("bp_pop_usage", usage, 1);
    chk("bp_pop_ready", elem_ready, 1);
    chk("bp_head_lane0", stu_data[63:0], 64'h24);
    for (int i = 8; i < 12; i++) feed(elen_t'(64'h20 + i), i == 11, 1'b0);
    drain(3);

    // Simultaneous push and pop at usage 1.
    for (int i = 0; i < 7; i++) feed(elen_t'(64'h30 + i), 1'b0, 1'b0);
    chk("pp_usage_before", usage, 1);
    cycle(1'b1, 64'h37, 1'b1, 1'b1, 1'b0);
    chk("pp_usage_after", usage, 1);
    chk("pp_head_lane0", stu_data[63:0], 64'h34);
    chk("pp_head_lane3", stu_data[255:192], 64'h37);
    drain(2);

    // Flush with a valid element presented.
    for (int i = 0; i < 6; i++) feed(elen_t'(64'h40 + i), 1'b0, 1'b0);
    chk("fl_usage_before", usage, 1);
    cycle(1'b1, 64'h99, 1'b0, 1'b0, 1'b1);
    check_reset_vals("flush");
    for (int i = 0; i < 4; i++) feed(elen_t'(64'h50 + i), i == 3, 1'b0);
    chk("fl_beat_lane0", stu_data[63:0], 64'h50);
    chk("fl_beat_lane3", stu_data[255:192], 64'h53);
    drain(2);

    // Asynchronous reset mid-vector, with one beat queued and 3 elements packed.
    for (int i = 0; i < 4; i++) feed(elen_t'(64'h58 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) feed(elen_t'(64'h60 + i), 1'b0, 1'b0);
    #2 rst_n = 0;
    #1;
    check_reset_vals("async_rst");
    model_clear();
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    drain(3);
    feed(64'h70, 1'b1, 1'b0);
    chk("rst_fresh_lane_en", stu_en, 4'b0001);
    chk("rst_fresh_lane1", stu_data[127:64], 0);
    drain(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
